// File: rtl/nabp_image_addresser_multimode_pkg.sv
// Shared types and helpers for the NABP image addressers.
package nabp_image_addresser_multimode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_SCAN_X = 2'd2,
        ST_SCAN_Y = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        X_ONLY   = 2'd0,
        Y_ONLY   = 2'd1,
        X_THEN_Y = 2'd2,
        RESERVED = 2'd3
    } scan_mode_t;

    typedef enum logic {
        DIR_X = 1'b0,
        DIR_Y = 1'b1
    } dir_t;

    // Counter/bus width for values 0..v-1; never narrower than one bit.
    function automatic int unsigned cw(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/nabp_scan_counter.sv
// Nested scan counter: pos s (0..N-1) inside line l (0..P-1) inside partition p.
// Ports: clk, reset_n (sync, active-low), clear, en (advance one step),
//        part_inc (let p advance when a partition wraps), s/l/p counts,
//        line_done / part_done / scan_done wrap flags for the current step.
module nabp_scan_counter
    import nabp_image_addresser_multimode_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE       = 128,
    parameter int unsigned PARTITION_SIZE   = 8,
    parameter int unsigned NO_OF_PARTITIONS = 16,
    localparam int unsigned S_W = cw(IMAGE_SIZE),
    localparam int unsigned L_W = cw(PARTITION_SIZE),
    localparam int unsigned P_W = cw(NO_OF_PARTITIONS)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           en,
    input  logic           part_inc,
    output logic [S_W-1:0] s,
    output logic [L_W-1:0] l,
    output logic [P_W-1:0] p,
    output logic           line_done,
    output logic           part_done,
    output logic           scan_done
);

    assign line_done = (s == S_W'(IMAGE_SIZE - 1));
    assign part_done = line_done && (l == L_W'(PARTITION_SIZE - 1));
    assign scan_done = part_done && (p == P_W'(NO_OF_PARTITIONS - 1));

    // s wraps into l, l wraps into p (p only when the caller allows it).
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            s <= '0;
            l <= '0;
            p <= '0;
        end else if (en) begin
            if (line_done) begin
                s <= '0;
                if (part_done) begin
                    l <= '0;
                    if (part_inc) begin
                        p <= scan_done ? '0 : p + P_W'(1);
                    end
                end else begin
                    l <= l + L_W'(1);
                end
            end else begin
                s <= s + S_W'(1);
            end
        end
    end

endmodule

// File: rtl/nabp_image_addresser_multimode.sv
// Image RAM address generator with X / Y / X-then-Y scan per partition.
// Ports: clk, reset_n (sync, active-low); host side hs_kick/hs_mode/hs_delay;
//        RAM side ir_enable in, ir_kick/ir_valid/ir_addr/ir_dir/ir_part/ir_done out;
//        status busy and sticky mode_err.
module nabp_image_addresser_multimode
    import nabp_image_addresser_multimode_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE       = 128,
    parameter int unsigned PARTITION_SIZE   = 8,
    parameter int unsigned NO_OF_PARTITIONS = 16,
    parameter int unsigned ADDR_W           = cw(IMAGE_SIZE * IMAGE_SIZE),
    parameter int unsigned DELAY_W          = 8,
    localparam int unsigned PART_W = cw(NO_OF_PARTITIONS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hs_kick,
    input  logic [1:0]         hs_mode,
    input  logic [DELAY_W-1:0] hs_delay,
    input  logic               ir_enable,
    output logic               ir_kick,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  ir_addr,
    output logic               ir_dir,
    output logic [PART_W-1:0]  ir_part,
    output logic               ir_done,
    output logic               busy,
    output logic               mode_err
);

    localparam int unsigned S_W = cw(IMAGE_SIZE);
    localparam int unsigned L_W = cw(PARTITION_SIZE);

    state_t             state_q, state_d;
    scan_mode_t         mode_q, mode_d;
    logic [DELAY_W-1:0] delay_q, delay_d, dcnt_q, dcnt_d;
    logic               err_q, err_d;
    // Offset accumulators: partition bases plus per-line (X) / per-pos (Y) strides.
    logic [ADDR_W-1:0]  xpart_q, xpart_d, ypart_q, ypart_d;
    logic [ADDR_W-1:0]  xline_q, xline_d, ys_q, ys_d;

    logic [S_W-1:0]     s;
    logic [L_W-1:0]     l;
    logic [PART_W-1:0]  p;
    logic               cnt_en, cnt_clear, part_inc;
    logic               line_done, part_done, scan_done;

    nabp_scan_counter #(
        .IMAGE_SIZE       (IMAGE_SIZE),
        .PARTITION_SIZE   (PARTITION_SIZE),
        .NO_OF_PARTITIONS (NO_OF_PARTITIONS)
    ) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (cnt_clear),
        .en        (cnt_en),
        .part_inc  (part_inc),
        .s         (s),
        .l         (l),
        .p         (p),
        .line_done (line_done),
        .part_done (part_done),
        .scan_done (scan_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= X_ONLY;
            delay_q <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
            xpart_q <= '0;
            ypart_q <= '0;
            xline_q <= '0;
            ys_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            delay_q <= delay_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            xpart_q <= xpart_d;
            ypart_q <= ypart_d;
            xline_q <= xline_d;
            ys_q    <= ys_d;
        end
    end

    // Next state, counter control and pulse outputs
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        delay_d   = delay_q;
        dcnt_d    = dcnt_q;
        err_d     = err_q;
        xpart_d   = xpart_q;
        ypart_d   = ypart_q;
        xline_d   = xline_q;
        ys_d      = ys_q;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
        part_inc  = 1'b1;
        ir_kick   = 1'b0;
        ir_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hs_kick) begin
                    // Reserved mode runs as X-then-Y but is flagged.
                    mode_d  = (hs_mode == 2'(RESERVED)) ? X_THEN_Y : scan_mode_t'(hs_mode);
                    err_d   = (hs_mode == 2'(RESERVED));
                    delay_d = hs_delay;
                    dcnt_d  = '0;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dcnt_q == delay_q) begin
                    ir_kick = 1'b1;
                    dcnt_d  = '0;
                    state_d = (mode_q == Y_ONLY) ? ST_SCAN_Y : ST_SCAN_X;
                end else begin
                    dcnt_d = dcnt_q + DELAY_W'(1);
                end
            end
            ST_SCAN_X, ST_SCAN_Y: begin
                if (ir_enable) begin
                    cnt_en  = 1'b1;
                    ys_d    = line_done ? '0 : ys_q + ADDR_W'(IMAGE_SIZE);
                    xline_d = part_done ? '0 :
                              line_done ? xline_q + ADDR_W'(IMAGE_SIZE) : xline_q;
                    if (part_done) begin
                        if (mode_q == X_THEN_Y && state_q == ST_SCAN_X) begin
                            // Same partition, now in Y.
                            part_inc = 1'b0;
                            state_d  = ST_SCAN_Y;
                        end else if (scan_done) begin
                            ir_done   = reset_n;
                            cnt_clear = 1'b1;
                            xpart_d   = '0;
                            ypart_d   = '0;
                            xline_d   = '0;
                            ys_d      = '0;
                            state_d   = ST_IDLE;
                        end else begin
                            xpart_d = xpart_q + ADDR_W'(PARTITION_SIZE * IMAGE_SIZE);
                            ypart_d = ypart_q + ADDR_W'(PARTITION_SIZE);
                            state_d = (mode_q == X_THEN_Y) ? ST_SCAN_X : state_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ir_valid = (state_q == ST_SCAN_X) || (state_q == ST_SCAN_Y);
    assign ir_dir   = (state_q == ST_SCAN_Y) ? DIR_Y : DIR_X;
    assign busy     = (state_q != ST_IDLE);
    assign ir_part  = p;
    assign mode_err = err_q;
    // Row-major in X, column-major in Y; all terms are zero outside a scan.
    assign ir_addr  = ir_dir ? (ys_q + ypart_q + ADDR_W'(l))
                             : (xpart_q + xline_q + ADDR_W'(s));

endmodule

// File: tb/tb_nabp_image_addresser_multimode.sv
// Scoreboard bench for nabp_image_addresser_multimode (N=8, P=2, 4 partitions).
module tb_nabp_image_addresser_multimode;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int NP = 4;

    typedef struct {
        int addr;
        int dir;
        int part;
        bit last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hs_kick;
    logic [1:0] hs_mode;
    logic [7:0] hs_delay;
    logic       ir_enable = 1'b0;
    logic       ir_kick, ir_valid, ir_dir, ir_done, busy, mode_err;
    logic [5:0] ir_addr;
    logic [1:0] ir_part;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    bit   en_rand = 1'b0;
    bit   en_hold = 1'b1;

    nabp_image_addresser_multimode #(
        .IMAGE_SIZE       (N),
        .PARTITION_SIZE   (P),
        .NO_OF_PARTITIONS (NP),
        .ADDR_W           (6),
        .DELAY_W          (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hs_kick   (hs_kick),
        .hs_mode   (hs_mode),
        .hs_delay  (hs_delay),
        .ir_enable (ir_enable),
        .ir_kick   (ir_kick),
        .ir_valid  (ir_valid),
        .ir_addr   (ir_addr),
        .ir_dir    (ir_dir),
        .ir_part   (ir_part),
        .ir_done   (ir_done),
        .busy      (busy),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence straight from the address formulas.
    task automatic build(input int mode);
        int   m;
        exp_t e;
        m = (mode == 3) ? 2 : mode;
        for (int pp = 0; pp < NP; pp++) begin
            for (int d = 0; d < 2; d++) begin
                if ((m == 0 && d == 1) || (m == 1 && d == 0)) continue;
                for (int ll = 0; ll < P; ll++) begin
                    for (int ss = 0; ss < N; ss++) begin
                        e.addr = (d == 0) ? (pp * P + ll) * N + ss : ss * N + pp * P + ll;
                        e.dir  = d;
                        e.part = pp;
                        e.last = (pp == NP - 1) && (ll == P - 1) && (ss == N - 1) && (m != 2 || d == 1);
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    // Enable driver: random back-pressure or a held level.
    always @(posedge clk) begin
        #1;
        ir_enable = en_rand ? ($urandom_range(0, 3) != 0) : en_hold;
    end

    // Monitor: every accepted address is matched against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n) begin
            if (ir_valid && ir_enable) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_addr", int'(ir_addr), -1);
                end else begin
                    e = q.pop_front();
                    check(int'(ir_addr) == e.addr, "addr", int'(ir_addr), e.addr);
                    check(int'(ir_dir) == e.dir, "dir", int'(ir_dir), e.dir);
                    check(int'(ir_part) == e.part, "part", int'(ir_part), e.part);
                    check(ir_done == e.last, "done_flag", int'(ir_done), int'(e.last));
                end
            end else if (ir_done) begin
                check(1'b0, "stray_done", 1, 0);
            end
            if (ir_done) done_cnt++;
        end
    end

    task automatic run(input int mode, input int dly, input bit rnd, input bit mid_kick,
                       input bit stall13, input bit abort);
        int k;
        int t;
        int base;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check(1'b0, "timeout_idle", t, 0);
        base = done_cnt;
        build(mode);
        @(posedge clk); #1;
        hs_mode = 2'(mode); hs_delay = 8'(dly); hs_kick = 1'b1;
        en_rand = rnd; en_hold = 1'b1;
        @(posedge clk); #1;
        hs_kick = 1'b0; hs_mode = 2'($urandom); hs_delay = 8'($urandom);
        k = 0;
        while (k <= 300) begin
            @(negedge clk);
            if (ir_kick) break;
            k++;
        end
        check(k == dly, "kick_latency", k, dly);
        check(mode_err == (mode == 3), "mode_err", int'(mode_err), int'(mode == 3));
        @(negedge clk);
        check(ir_valid == 1'b1, "first_valid", int'(ir_valid), 1);
        check(ir_addr == 6'd0, "first_addr", int'(ir_addr), 0);

        if (mid_kick) begin
            repeat (20) @(posedge clk);
            #1 hs_kick = 1'b1; hs_mode = 2'($urandom);
            @(posedge clk); #1 hs_kick = 1'b0;
        end

        if (stall13) begin
            t = 0;
            while (!(ir_valid && !ir_dir && ir_addr == 6'd12) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check(1'b0, "timeout_stall", t, 0);
            en_hold = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check(ir_addr == 6'd13, "stall_hold", int'(ir_addr), 13);
                check(ir_valid == 1'b1, "stall_valid", int'(ir_valid), 1);
            end
            en_hold = 1'b1;
        end

        if (abort) begin
            // Hit reset exactly while the final address is being accepted.
            t = 0;
            while (t < 2000) begin
                @(posedge clk); #1;
                if (ir_valid && ir_dir && ir_addr == 6'd63 && ir_part == 2'd3) break;
                t++;
            end
            if (t >= 2000) check(1'b0, "timeout_abort", t, 0);
            reset_n = 1'b0;
            @(negedge clk);
            check(ir_done == 1'b0, "abort_no_done", int'(ir_done), 0);
            @(posedge clk); #1;
            check(busy == 1'b0, "abort_busy", int'(busy), 0);
            check(ir_addr == 6'd0, "abort_addr", int'(ir_addr), 0);
            check(ir_valid == 1'b0, "abort_valid", int'(ir_valid), 0);
            reset_n = 1'b1;
            q.delete();
            check(done_cnt == base, "abort_done_cnt", done_cnt - base, 0);
        end else begin
            t = 0;
            while (busy && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) check(1'b0, "timeout_run", t, 0);
            check(q.size() == 0, "queue_drained", q.size(), 0);
            check(done_cnt - base == 1, "done_count", done_cnt - base, 1);
        end
    endtask

    initial begin
        reset_n = 1'b0; hs_kick = 1'b0; hs_mode = 2'd0; hs_delay = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(ir_valid == 1'b0, "rst_valid", int'(ir_valid), 0);
        check(ir_addr == 6'd0, "rst_addr", int'(ir_addr), 0);
        check(ir_kick == 1'b0, "rst_kick", int'(ir_kick), 0);
        check(ir_done == 1'b0, "rst_done", int'(ir_done), 0);
        check(mode_err == 1'b0, "rst_mode_err", int'(mode_err), 0);
        check(ir_part == 2'd0, "rst_part", int'(ir_part), 0);
        check(ir_dir == 1'b0, "rst_dir", int'(ir_dir), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        run(2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run(0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(3, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        run(0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        run(2, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b1,
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nabp_image_addresser_multimode.md
Name: nabp_image_addresser_multimode

Overview:
- Parametrised successor of the image address generator.
- Produces Image RAM addresses for values streamed out of the PE domino chain, one partition (a band of PART_SIZE lines) at a time.
- Adds a runtime-selectable scan mode: X-only, Y-only, or X-then-Y per partition.
- Adds a programmable pre-kick delay, an address-valid qualifier, and partition/direction status outputs.
- Sits between the host kick and the Image RAM controller.

Parameters:
- IMAGE_SIZE, 128, image side length N in pixels.
- PARTITION_SIZE, 8, lines per partition P; IMAGE_SIZE must equal PARTITION_SIZE*NO_OF_PARTITIONS.
- NO_OF_PARTITIONS, 16, partitions (PEs) per image.
- ADDR_W, clog2(IMAGE_SIZE*IMAGE_SIZE), Image RAM address width.
- DELAY_W, 8, width of the runtime delay count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- hs_kick  in  1  host start pulse; sampled only in IDLE.
- hs_mode  in  2  scan mode, latched on an accepted kick: 0 X-only, 1 Y-only, 2 X-then-Y, 3 reserved.
- hs_delay  in  DELAY_W  pre-kick delay cycles, latched on an accepted kick.
- ir_enable  in  1  RAM accepts the current address; advances the scan.
- ir_kick  out  1  one-cycle pulse: addresses about to start.
- ir_valid  out  1  ir_addr is meaningful (high in SCAN_X/SCAN_Y).
- ir_addr  out  ADDR_W  current address.
- ir_dir  out  1  0 = X scan, 1 = Y scan.
- ir_part  out  clog2(NO_OF_PARTITIONS)  current partition index.
- ir_done  out  1  one-cycle pulse coincident with acceptance of the final address.
- busy  out  1  high whenever state is not IDLE.
- mode_err  out  1  sticky flag: hs_mode==3 was kicked; cleared on the next accepted kick.

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- Reset has priority over everything, including mid-scan; no ir_done is issued on abort.
- States: IDLE, DELAY, SCAN_X, SCAN_Y.
- IDLE:
  - On hs_kick: latch mode and delay, go to DELAY.
  - mode 3 is executed as mode 2 and sets mode_err.
  - hs_kick outside IDLE is ignored.
- DELAY:
  - Counter runs 0..hs_delay; ir_kick pulses in the cycle the counter equals hs_delay.
  - Next state is SCAN_X for modes 0/2, SCAN_Y for mode 1.
  - hs_delay=0 gives exactly one DELAY cycle, with ir_kick in that cycle.
- Scan counters: part p, line l (0..P-1), pos s (0..N-1). ir_addr is valid combinationally from the registered counters.
- SCAN_X address = (p*P + l)*N + s (row-major over the partition's rows).
- SCAN_Y address = s*N + p*P + l (column-major over the partition's columns).
- Address arithmetic:
  - Incremental adders only, no multipliers.
  - Partition offsets advance by P*N (X) and P (Y) at a partition boundary.
  - All arithmetic is modulo 2^ADDR_W; no value ever exceeds N*N-1.
- Advance only when ir_enable=1 in a SCAN state. ir_enable=0 holds all counters and ir_addr (stall of any length). ir_enable in IDLE/DELAY is ignored.
- On accept:
  - s increments; at s=N-1 it wraps to 0 and l increments.
  - At l=P-1 with s=N-1 the partition scan ends.
- End of a partition scan:
  - Mode 2, SCAN_X: go to SCAN_Y with the same p.
  - Mode 2, SCAN_Y: p+1, go to SCAN_X.
  - Modes 0/1: p+1, stay in the same state.
  - If p = NO_OF_PARTITIONS-1 and the final direction is complete: ir_done pulses and the state goes to IDLE next cycle.
  - hs_kick in that same cycle is ignored.
- Throughput: one address per cycle with ir_enable held high. No bubble at line, direction or partition boundaries.
- Address counts per run: N*N for modes 0/1, 2*N*N for mode 2.

Decomposition:
- Shared package: state encoding, scan-mode enum (X_ONLY, Y_ONLY, X_THEN_Y, RESERVED), direction enum, and a width-helper constant function used by all addressers.
- One sub-module, nabp_scan_counter: a nested s/l/p counter with enable, wrap flags (scan_done, line_done, part_done) and clear.
- The top level holds the FSM, the delay counter and the offset adders.

Test Plan (N=8, P=2, NO_OF_PARTITIONS=4, ir_enable=1 unless stated):
- Mode 2, hs_delay=3:
  - ir_kick is exactly 4 cycles after the accepted kick.
  - Partition 0 X gives 0..15; Y gives 0,8,..,56,1,9,..,57.
  - Partition 1 X starts at 16.
  - 128 addresses in total; the last is 63, with ir_done on it.
- Mode 0: 64 addresses 0..63 in order; ir_dir is always 0; ir_part steps at addresses 16, 32, 48.
- Mode 1: sequence 0,8,..,56,1,..,57,2,..; last address 63; ir_dir is always 1.
- Stall: drop ir_enable for 5 cycles at address 13 of the X scan.
  - ir_addr holds 13 throughout; the next accepted address is 14.
  - No address is skipped or duplicated.
- Robustness:
  - hs_kick asserted mid-scan is ignored.
  - reset_n low mid-scan: next cycle IDLE, busy=0, ir_addr=0, no ir_done.
  - hs_mode=3: behaves as mode 2 and mode_err=1; the next kick with mode 0 clears mode_err.
- hs_delay=0: ir_kick in the first DELAY cycle; the first address (0) is valid on the following cycle.
